temp_sensor_reader: RTL and testbench
=====================================

// Module: temp_sensor_reader
// PURPOSE
//   Serial master that periodically reads an external temperature sensor over a 3-wire link
//   (cs_n/sclk/miso). Each reading is a 10-bit frame. The block checks the frame and
//   presents the result as temp_data plus a one-cycle temp_valid strobe.
//   It is the producer side of the temp_data input consumed by temp_analyzer in top_temp.
// PARAMETERS
//   CLK_DIV        4     clk cycles per sclk half-period; legal minimum 3 (covers miso synchronizer)
//   SAMPLE_PERIOD  1000  clk cycles between automatic conversion triggers; must exceed conversion length
//   FRAME_BITS     10    bits per frame: sync + 8 data + parity (fixed by sensor)
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset (0 = reset)
//   enable     in   1  1 = periodic conversions run; 0 = timer held at 0, no auto triggers
//   start      in   1  one-cycle request for an immediate conversion; honoured only in IDLE
//   sens_cs_n  out  1  sensor chip select, active low
//   sens_sclk  out  1  sensor serial clock, idles low
//   sens_miso  in   1  sensor serial data (asynchronous to clk)
//   temp_data  out  8  last good temperature reading
//   temp_valid out  1  one-cycle pulse when temp_data is updated
//   sens_err   out  1  one-cycle pulse when a frame is rejected
//   err_cnt    out  4  rejected-frame count, saturating
//   busy       out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//   Reset values: sens_cs_n=1, sens_sclk=0, temp_data=8'h00, temp_valid=0, sens_err=0,
//   err_cnt=0, busy=0, FSM=IDLE, sample timer=0, shift register=0.
//   Reset asserted mid-conversion aborts at once: cs_n=1, sclk=0, with no valid or err pulse.
//   sens_miso passes through a 2-flop synchronizer before use.
//   Sample timer: counts while enable=1 and wraps at SAMPLE_PERIOD-1. The wrap is a trigger.
//     enable=0 clears the timer. Triggers (timer wrap or start) while busy are dropped, not queued.
//     A start and a timer wrap in the same cycle produce one conversion.
//   FSM states and transitions:
//     IDLE     -> CS_SETUP on trigger. sens_cs_n falls in the next cycle (call it T0).
//     CS_SETUP -> lasts CLK_DIV cycles with sclk low, then -> SHIFT.
//     SHIFT    -> FRAME_BITS sclk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
//                 Bits arrive MSB first.
//                 The synchronized miso is captured in the last clk cycle of each sclk-high phase.
//     CS_HOLD  -> lasts CLK_DIV cycles with sclk low and cs_n still low, then -> CHECK.
//     CHECK    -> 1 cycle. cs_n returns to 1 here. Then -> IDLE.
//   Frame layout: bit9 = sync (must be 0), bits8..1 = temperature[7:0],
//     bit0 = parity = ^temperature[7:0].
//   Frame is good when sync==0 and parity matches. A good frame updates temp_data and pulses
//     temp_valid together, one cycle after CHECK.
//   Frame is bad otherwise. temp_data holds its value, sens_err pulses at the same point, and
//     err_cnt increments and stays at 15 once reached.
//   Latency: temp_valid/sens_err assert at T0 + CLK_DIV*(2*FRAME_BITS+2) + 1 (defaults: T0+89).
//   enable falling mid-conversion: the current frame completes normally.
//   temp_data is stable between temp_valid pulses and is safe for direct use by temp_analyzer.
// TESTING (defaults: CLK_DIV=4, SAMPLE_PERIOD=1000)
//   1. Reset low for 3 cycles, then high with enable=0 -> all outputs at reset values,
//      cs_n stays 1, no sclk activity.
//   2. start pulse; sensor model drives 0_01010000_0 -> temp_data=8'h50, temp_valid high
//      for exactly 1 cycle at T0+89, err_cnt=0.
//   3. Sensor drives 0_01010000_1 (bad parity) -> sens_err pulse at T0+89,
//      temp_data stays 8'h50, err_cnt=1.
//   4. Sensor drives sync bit=1 for 16 consecutive frames -> 16 sens_err pulses,
//      err_cnt reaches 15 and stays 15.
//   5. enable=1 for 5000 cycles -> cs_n falls exactly every 1000 cycles;
//      a start pulse issued while busy=1 causes no extra frame.
//   6. Reset asserted in the 5th sclk period of SHIFT -> cs_n=1 and sclk=0 in the same cycle,
//      temp_data=0, no valid pulse; the next start yields a correct frame.

Source files
------------

// File: rtl/temp_sensor_reader.sv
// rtl/temp_sensor_reader.sv - periodic 3-wire temperature sensor reader with frame check
module temp_sensor_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FRAME_BITS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    output logic       sens_cs_n,
    output logic       sens_sclk,
    input  logic       sens_miso,
    output logic [7:0] temp_data,
    output logic       temp_valid,
    output logic       sens_err,
    output logic [3:0] err_cnt,
    output logic       busy
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int BIT_W = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CHECK
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  sclk_phase;
    logic [TMR_W-1:0]      timer;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  miso_meta;
    logic                  miso_sync;
    logic                  timer_wrap;
    logic                  trigger;
    logic                  div_done;
    logic                  last_bit;
    logic                  frame_ok;

    assign timer_wrap = enable && (timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign trigger    = start || timer_wrap;
    assign div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    // Sync bit must be 0 and the trailing bit must equal the XOR of the data byte.
    assign frame_ok   = !shift_reg[FRAME_BITS-1] &&
                        ((^shift_reg[FRAME_BITS-2:1]) == shift_reg[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sens_cs_n  = 1'b0;
        sens_sclk  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                sens_cs_n = 1'b1;
                busy      = 1'b0;
                if (trigger) state_next = CS_SETUP;
            end
            CS_SETUP: begin
                if (div_done) state_next = SHIFT;
            end
            SHIFT: begin
                sens_sclk = sclk_phase;
                if (div_done && !sclk_phase && last_bit) state_next = CS_HOLD;
            end
            CS_HOLD: begin
                if (div_done) state_next = CHECK;
            end
            CHECK: begin
                sens_cs_n  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                sens_cs_n  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
            timer     <= '0;
        end else begin
            miso_meta <= sens_miso;
            miso_sync <= miso_meta;
            if (!enable || timer_wrap) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Bit timing: each SHIFT bit is one high phase then one low phase of CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sclk_phase <= 1'b1;
            shift_reg  <= '0;
        end else begin
            if (state == IDLE || state == CHECK) begin
                div_cnt <= '0;
            end else if (div_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state == SHIFT) begin
                if (div_done) sclk_phase <= ~sclk_phase;
                if (div_done && !sclk_phase) bit_cnt <= bit_cnt + 1'b1;
                if (div_done && sclk_phase) shift_reg <= {shift_reg[FRAME_BITS-2:0], miso_sync};
            end else begin
                sclk_phase <= 1'b1;
                bit_cnt    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_data  <= 8'h00;
            temp_valid <= 1'b0;
            sens_err   <= 1'b0;
            err_cnt    <= 4'd0;
        end else begin
            temp_valid <= (state == CHECK) && frame_ok;
            sens_err   <= (state == CHECK) && !frame_ok;
            if (state == CHECK) begin
                if (frame_ok) begin
                    temp_data <= shift_reg[FRAME_BITS-2:1];
                end else if (err_cnt != 4'hF) begin
                    err_cnt <= err_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb/tb_temp_sensor_reader.sv - self-checking bench for temp_sensor_reader
module tb_temp_sensor_reader;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic       sens_cs_n;
    logic       sens_sclk;
    logic       sens_miso = 1'b0;
    logic [7:0] temp_data;
    logic       temp_valid;
    logic       sens_err;
    logic [3:0] err_cnt;
    logic       busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;

    localparam int LATENCY = 4 * (2 * 10 + 2) + 1;

    temp_sensor_reader dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .sens_cs_n  (sens_cs_n),
        .sens_sclk  (sens_sclk),
        .sens_miso  (sens_miso),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .sens_err   (sens_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor: first bit on cs_n fall, each following bit on an sclk falling edge.
    logic [9:0] sensor_frame = 10'd0;
    int         sens_idx     = 10;
    always @(sens_cs_n or negedge sens_sclk) begin
        if (sens_cs_n) begin
            sens_idx = 10;
        end else if (sens_idx > 0) begin
            sens_idx  = sens_idx - 1;
            sens_miso = sensor_frame[sens_idx];
        end
    end

    logic [7:0] exp_data   = 8'h00;
    logic [3:0] exp_errcnt = 4'd0;

    function automatic bit frame_good(input logic [9:0] f);
        int ones = 0;
        for (int i = 1; i <= 8; i++) ones += f[i];
        return (f[9] == 1'b0) && ((ones % 2) == f[0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_apply(input bit good, input logic [7:0] d);
        if (good) exp_data = d;
        else if (exp_errcnt != 4'hF) exp_errcnt = exp_errcnt + 4'd1;
    endtask

    task automatic conv_and_check(input logic [9:0] f, input bit exp_good,
                                  input logic [7:0] exp_d, input string tag);
        int t0  = -1;
        int lat = -1;
        bit got_v = 0;
        bit got_e = 0;
        sensor_frame = f;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!sens_cs_n) begin
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, " cs_fall"}, (t0 >= 0), 1);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (temp_valid || sens_err) begin
                lat   = cyc - t0;
                got_v = temp_valid;
                got_e = sens_err;
                break;
            end
        end
        model_apply(exp_good, exp_d);
        check({tag, " latency"}, lat, LATENCY);
        check({tag, " valid"}, got_v, exp_good);
        check({tag, " err"}, got_e, !exp_good);
        check({tag, " data"}, temp_data, exp_data);
        check({tag, " err_cnt"}, err_cnt, exp_errcnt);
        @(negedge clk);
        check({tag, " pulse_width"}, {temp_valid, sens_err}, 2'b00);
    endtask

    typedef struct {
        logic [9:0] frame;
        bit         good;
        logic [7:0] data;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   viol;
        int   falls;
        int   valids;
        int   bad_gap;
        int   last_fall;
        int   t0;
        bit   prev_cs;
        logic [9:0] f;

        vecs[0] = '{10'b0_01010000_0, 1'b1, 8'h50};
        vecs[1] = '{10'b0_01010000_1, 1'b0, 8'h50};
        vecs[2] = '{10'b0_11111111_0, 1'b1, 8'hFF};
        vecs[3] = '{10'b1_00000000_0, 1'b0, 8'hFF};
        vecs[4] = '{10'b0_00000001_1, 1'b1, 8'h01};
        vecs[5] = '{10'b0_10000000_0, 1'b0, 8'h01};

        reset  = 1'b0;
        enable = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cs_n", sens_cs_n, 1);
        check("rst sclk", sens_sclk, 0);
        check("rst outputs", {temp_data, temp_valid, sens_err, err_cnt, busy}, 0);
        reset = 1'b1;
        viol  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!sens_cs_n || sens_sclk || busy || temp_valid || sens_err) viol++;
        end
        check("idle quiet", viol, 0);

        for (int i = 0; i < 6; i++) conv_and_check(vecs[i].frame, vecs[i].good, vecs[i].data, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            f = {1'b1, 9'($urandom_range(0, 511))};
            conv_and_check(f, frame_good(f), f[8:1], $sformatf("sync%0d", i));
        end
        check("err_cnt saturated", err_cnt, 4'hF);

        for (int i = 0; i < 20; i++) begin
            f = 10'($urandom_range(0, 1023));
            if (i % 2 == 0) f[0] = ^f[8:1];
            conv_and_check(f, frame_good(f), f[8:1], $sformatf("rand%0d", i));
        end

        sensor_frame = 10'b0_00110011_0;
        falls = 0; valids = 0; bad_gap = 0; last_fall = -1;
        prev_cs = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (prev_cs && !sens_cs_n) begin
                if (last_fall < 0) check("first auto fall", i, 999);
                else if (i - last_fall != 1000) bad_gap++;
                last_fall = i;
                falls++;
            end
            prev_cs = sens_cs_n;
            if (temp_valid) valids++;
            if (i == 1020) begin
                check("busy at start", busy, 1);
                start = 1'b1;
            end
            if (i == 1021) start = 1'b0;
        end
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) begin
            @(negedge clk);
            if (temp_valid) valids++;
        end
        @(negedge clk);
        if (temp_valid) valids++;
        check("auto falls", falls, 5000 / 1000);
        check("auto spacing", bad_gap, 0);
        check("auto frames", valids, 5);
        model_apply(1'b1, 8'h33);
        check("auto data", temp_data, exp_data);
        check("auto err_cnt", err_cnt, exp_errcnt);

        sensor_frame = 10'b0_01100110_0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 38) @(negedge clk);
        check("shift5 sclk high", sens_sclk, 1);
        reset = 1'b0;
        #1;
        check("abort cs_n", sens_cs_n, 1);
        check("abort sclk", sens_sclk, 0);
        check("abort state", {temp_data, err_cnt, busy}, 0);
        exp_data   = 8'h00;
        exp_errcnt = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        viol  = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (temp_valid || sens_err || !sens_cs_n) viol++;
        end
        check("no pulse after abort", viol, 0);
        conv_and_check(10'b0_01100110_0, 1'b1, 8'h66, "post_abort");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
